// File: rtl/mac_pipe.sv
// Pipelined fixed-point multiply-accumulate: streams (a, x) element pairs and
// hands the dot product to a downstream join stage with a valid/consume handshake.
module mac_pipe #(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int MAX_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_a,
  input  logic [DATA_SIZE-1:0] in_x,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 consume,
  output logic [DATA_SIZE-1:0] data_pipe,
  output logic                 data_ready,
  output logic                 overflow_flag,
  output logic                 len_error
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int PW = 2 * DATA_SIZE;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]        count_q;
  logic [DATA_SIZE-1:0] op_a_q, op_x_q;
  logic                 op_valid_q, op_first_q, op_last_q;
  logic [DATA_SIZE-1:0] acc_q, data_pipe_q;
  logic                 data_ready_q, overflow_q, len_error_q;

  logic                 accept, eff_last, first_elem, abort;
  logic signed [PW-1:0] prod_full, prod_shift;
  logic [DATA_SIZE-1:0] prod, sum, acc_d;
  logic                 prod_ovf, add_ovf;

  assign abort      = rst | clear;
  assign accept     = in_valid & in_ready;
  assign first_elem = (count_q == '0);
  // The MAX_LEN-th element closes the vector even without in_last.
  assign eff_last   = in_last | (count_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (abort) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = eff_last ? DRAIN : ACCUM;
      DRAIN:       state_d = HOLD;
      HOLD:        if (consume) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE, ACCUM: in_ready = 1'b1;
      default:     in_ready = 1'b0;
    endcase
  end

  // Product of the registered operands, rescaled back to FRAC_BITS.
  assign prod_full  = PW'($signed(op_a_q)) * PW'($signed(op_x_q));
  assign prod_shift = prod_full >>> FRAC_BITS;
  assign prod       = prod_shift[DATA_SIZE-1:0];
  assign prod_ovf   = !((&prod_shift[PW-1:DATA_SIZE-1]) || !(|prod_shift[PW-1:DATA_SIZE-1]));
  assign sum        = acc_q + prod;
  assign add_ovf    = !op_first_q && (acc_q[DATA_SIZE-1] == prod[DATA_SIZE-1])
                      && (sum[DATA_SIZE-1] != prod[DATA_SIZE-1]);
  assign acc_d      = op_first_q ? prod : sum;

  // Operand payload carries no reset; op_valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (accept && !abort) begin
      op_a_q     <= in_a;
      op_x_q     <= in_x;
      op_last_q  <= eff_last;
      op_first_q <= first_elem;
    end
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      op_valid_q   <= 1'b0;
      count_q      <= '0;
      acc_q        <= '0;
      data_pipe_q  <= '0;
      data_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      len_error_q  <= 1'b0;
    end else begin
      op_valid_q <= accept;
      if (accept) begin
        count_q <= count_q + CW'(1);
        if (first_elem) begin
          overflow_q  <= 1'b0;
          len_error_q <= 1'b0;
        end
        if (!in_last && count_q == LAST_IDX) len_error_q <= 1'b1;
      end
      if (op_valid_q) begin
        acc_q <= acc_d;
        if (prod_ovf || add_ovf) overflow_q <= 1'b1;
        if (op_last_q) begin
          data_pipe_q  <= acc_d;
          data_ready_q <= 1'b1;
        end
      end
      if (state_q == HOLD && consume) begin
        data_ready_q <= 1'b0;
        count_q      <= '0;
      end
    end
  end

  assign data_pipe     = data_pipe_q;
  assign data_ready    = data_ready_q;
  assign overflow_flag = overflow_q;
  assign len_error     = len_error_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: one default instance, one MAX_LEN=4 instance,
// and both joined through a shared consume for the release test.
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        rst, join_mode;
  logic        clear_a, a_valid, a_last, a_rdy, a_cons, a_cons_w, a_dr, a_ovf, a_len;
  logic [15:0] a_a, a_x, a_dp;
  logic        clear_b, b_valid, b_last, b_rdy, b_cons, b_cons_w, b_dr, b_ovf, b_len;
  logic [15:0] b_a, b_x, b_dp;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          base, a_rise, b_rise, a_fall, b_fall;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  assign a_cons_w = join_mode ? (a_dr & b_dr) : a_cons;
  assign b_cons_w = join_mode ? (a_dr & b_dr) : b_cons;

  mac_pipe u_dut (
    .clk(clk), .rst(rst), .clear(clear_a), .in_valid(a_valid), .in_a(a_a), .in_x(a_x),
    .in_last(a_last), .in_ready(a_rdy), .consume(a_cons_w), .data_pipe(a_dp),
    .data_ready(a_dr), .overflow_flag(a_ovf), .len_error(a_len)
  );

  mac_pipe #(.MAX_LEN(4)) u_len4 (
    .clk(clk), .rst(rst), .clear(clear_b), .in_valid(b_valid), .in_a(b_a), .in_x(b_x),
    .in_last(b_last), .in_ready(b_rdy), .consume(b_cons_w), .data_pipe(b_dp),
    .data_ready(b_dr), .overflow_flag(b_ovf), .len_error(b_len)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_a(input logic [15:0] a, input logic [15:0] x, input logic last);
    a_valid = 1'b1; a_a = a; a_x = x; a_last = last;
  endtask

  task automatic drive_b(input logic [15:0] a, input logic [15:0] x, input logic last);
    b_valid = 1'b1; b_a = a; b_x = x; b_last = last;
  endtask

  task automatic pop_cmp(input string tag, input bit sel_b, input logic [15:0] obs);
    int          n;
    logic [15:0] e;
    n = sel_b ? exp_b.size() : exp_a.size();
    check({tag, "_sb_pending"}, 32'(n > 0), 32'd1);
    if (n > 0) begin
      if (sel_b) e = exp_b.pop_front();
      else       e = exp_a.pop_front();
      check({tag, "_data"}, obs, e);
    end
  endtask

  // Called right after the edge that accepted the last element.
  task automatic wait_result(input string tag, input bit sel_b, input int exp_lat);
    int n = 0;
    while (!(sel_b ? b_dr : a_dr) && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    pop_cmp(tag, sel_b, sel_b ? b_dp : a_dp);
  endtask

  task automatic release_res(input string tag, input bit sel_b);
    if (sel_b) b_cons = 1'b1; else a_cons = 1'b1;
    step();
    b_cons = 1'b0; a_cons = 1'b0;
    check({tag, "_rel_dr"},  sel_b ? b_dr : a_dr, 1'b0);
    check({tag, "_rel_rdy"}, sel_b ? b_rdy : a_rdy, 1'b1);
  endtask

  task automatic sample6();
    int t = cyc - base;
    if (a_dr && a_rise < 0) begin a_rise = t; pop_cmp("s6_a", 1'b0, a_dp); end
    if (b_dr && b_rise < 0) begin
      b_rise = t;
      pop_cmp("s6_b", 1'b1, b_dp);
      check("s6_b_len", b_len, 1'b0);
    end
    if (!a_dr && a_rise >= 0 && a_fall < 0) a_fall = t;
    if (!b_dr && b_rise >= 0 && b_fall < 0) b_fall = t;
  endtask

  initial begin
    rst = 1'b1; join_mode = 1'b0;
    clear_a = 0; a_valid = 0; a_a = 0; a_x = 0; a_last = 0; a_cons = 0;
    clear_b = 0; b_valid = 0; b_a = 0; b_x = 0; b_last = 0; b_cons = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_dr",   a_dr,  1'b0);
    check("rst_rdy",  a_rdy, 1'b1);
    check("rst_dp",   a_dp,  16'h0000);
    check("rst_ovf",  a_ovf, 1'b0);
    check("rst_len",  a_len, 1'b0);
    check("rst_rdy4", b_rdy, 1'b1);

    // Scenario 1: 1.0*3.0 + 2.0*0.5 = 4.0
    drive_a(16'h0100, 16'h0300, 1'b0);
    step();
    check("s1_rdy_accum", a_rdy, 1'b1);
    drive_a(16'h0200, 16'h0080, 1'b1);
    exp_a.push_back(16'h0400);
    step();
    a_valid = 1'b0;
    check("s1_rdy_drain", a_rdy, 1'b0);
    wait_result("s1", 1'b0, 1);
    check("s1_ovf", a_ovf, 1'b0);
    release_res("s1", 1'b0);

    // Scenario 2: -1.0*2.0, held, then consume collides with in_valid
    drive_a(16'hFF00, 16'h0200, 1'b1);
    exp_a.push_back(16'hFE00);
    step();
    a_valid = 1'b0;
    wait_result("s2", 1'b0, 1);
    drive_a(16'h0100, 16'h0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("s2_hold_dr",  a_dr,  1'b1);
      check("s2_hold_dp",  a_dp,  16'hFE00);
      check("s2_hold_rdy", a_rdy, 1'b0);
    end
    a_cons = 1'b1;
    step();
    a_cons = 1'b0;
    check("s2_rel_dr",  a_dr,  1'b0);
    check("s2_rel_rdy", a_rdy, 1'b1);
    exp_a.push_back(16'h0100);
    step();
    a_valid = 1'b0;
    wait_result("s2_next", 1'b0, 1);
    release_res("s2_next", 1'b0);

    // Scenario 3: product overflow, sticky through HOLD, cleared by next first accept
    drive_a(16'h7F00, 16'h0200, 1'b1);
    exp_a.push_back(16'hFE00);
    step();
    a_valid = 1'b0;
    wait_result("s3", 1'b0, 1);
    check("s3_ovf", a_ovf, 1'b1);
    step();
    check("s3_ovf_hold", a_ovf, 1'b1);
    release_res("s3", 1'b0);
    check("s3_ovf_idle", a_ovf, 1'b1);
    drive_a(16'h0100, 16'h0200, 1'b1);
    exp_a.push_back(16'h0200);
    step();
    a_valid = 1'b0;
    check("s3_ovf_clr", a_ovf, 1'b0);
    wait_result("s3_next", 1'b0, 1);
    check("s3_next_ovf", a_ovf, 1'b0);
    release_res("s3_next", 1'b0);

    // Scenario 3b: accumulate overflow 0x7000 + 0x7000 wraps
    drive_a(16'h7000, 16'h0100, 1'b0);
    step();
    drive_a(16'h7000, 16'h0100, 1'b1);
    exp_a.push_back(16'hE000);
    step();
    a_valid = 1'b0;
    wait_result("s3b", 1'b0, 1);
    check("s3b_ovf", a_ovf, 1'b1);
    release_res("s3b", 1'b0);

    // Scenario 4: MAX_LEN=4 reached without in_last
    exp_b.push_back(16'h0400);
    for (int i = 0; i < 4; i++) begin
      drive_b(16'h0100, 16'h0100, 1'b0);
      step();
    end
    b_valid = 1'b0;
    check("s4_rdy_drain", b_rdy, 1'b0);
    check("s4_len_set",   b_len, 1'b1);
    wait_result("s4", 1'b1, 1);
    check("s4_len", b_len, 1'b1);
    drive_b(16'h0300, 16'h0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s4_hold_rdy", b_rdy, 1'b0);
      check("s4_hold_dp",  b_dp,  16'h0400);
    end
    b_valid = 1'b0;
    release_res("s4", 1'b1);
    check("s4_len_idle", b_len, 1'b1);
    drive_b(16'h0100, 16'h0100, 1'b1);
    exp_b.push_back(16'h0100);
    step();
    b_valid = 1'b0;
    check("s4_len_clr", b_len, 1'b0);
    wait_result("s4_next", 1'b1, 1);
    release_res("s4_next", 1'b1);

    // Scenario 5: clear one cycle after the 2nd of 3 elements
    drive_a(16'h0500, 16'h0100, 1'b0);
    step();
    drive_a(16'h0300, 16'h0100, 1'b0);
    step();
    drive_a(16'h0200, 16'h0100, 1'b1);
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    a_valid = 1'b0;
    check("s5_dr",  a_dr,  1'b0);
    check("s5_rdy", a_rdy, 1'b1);
    check("s5_dp",  a_dp,  16'h0000);
    drive_a(16'h0100, 16'h0100, 1'b1);
    exp_a.push_back(16'h0100);
    step();
    a_valid = 1'b0;
    wait_result("s5", 1'b0, 1);
    // Clear while holding a result
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    check("s5_hold_clr_dr",  a_dr,  1'b0);
    check("s5_hold_clr_dp",  a_dp,  16'h0000);
    check("s5_hold_clr_rdy", a_rdy, 1'b1);

    // Scenario 6: both instances released together by the join stage
    join_mode = 1'b1;
    base = cyc; a_rise = -1; b_rise = -1; a_fall = -1; b_fall = -1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        drive_a(16'h0200, 16'h0100, 1'b1);
        exp_a.push_back(16'h0200);
      end else begin
        a_valid = 1'b0;
      end
      drive_b(16'h0100, 16'h0080, i == 3);
      if (i == 3) exp_b.push_back(16'h0200);
      step();
      sample6();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      sample6();
    end
    check("s6_a_rise", a_rise, 2);
    check("s6_b_rise", b_rise, 5);
    check("s6_a_fall", a_fall, 6);
    check("s6_b_fall", b_fall, 6);
    check("s6_rdy_a",  a_rdy,  1'b1);
    check("s6_rdy_b",  b_rdy,  1'b1);
    join_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
